// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared helpers for the pipelined 4:1 mux tree
//
// Purpose: tree-depth function, per-stage word count helper and the
// elaboration guard that rejects channel counts that are not a power of 4.
// Ports: none (package).

`ifndef MUX_TREE_PKG_SV
`define MUX_TREE_PKG_SV

// Place inside a module body: fails elaboration unless n is a power of 4 and >= 4.
`define MUX_TREE_ASSERT_POW4(n) \
  if (!mux_tree_pkg::is_pow4(n)) begin : g_bad_n_in \
    $error("mux_tree: N_IN must be a power of 4 and >= 4"); \
  end

package mux_tree_pkg;

  // Number of 4:1 levels needed to reduce n words to one.
  function automatic int clog4(input int n);
    int v;
    int l;
    v = n;
    l = 0;
    while (v > 1) begin
      v = v >> 2;
      l = l + 1;
    end
    return l;
  endfunction

  function automatic bit is_pow4(input int n);
    int v;
    if (n < 4) return 1'b0;
    v = n;
    while (v > 1) begin
      if ((v % 4) != 0) return 1'b0;
      v = v / 4;
    end
    return 1'b1;
  endfunction

  // Words held in the registers of stage k.
  function automatic int stage_words(input int n_in, input int k);
    return n_in >> (2 * (k + 1));
  endfunction

endpackage

`endif

// File: rtl/mux4_stage.sv
// rtl/mux4_stage.sv - one registered level of the 4:1 mux tree
//
// Purpose: GROUPS parallel 4:1 selects feeding a register bank, with the
// level's valid bit and its link in the combinational ready chain.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   src_data        4*GROUPS words from the level above (group g = words 4g..4g+3)
//   src_sel         full select travelling with the upstream item
//   src_valid       upstream item present
//   ready           this level can take an item this cycle
//   data            GROUPS registered words
//   sel             registered full select
//   valid           registered item present
//   dst_ready       downstream level (or consumer) accepts this cycle

module mux4_stage
  import mux_tree_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GROUPS = 1,
  parameter int SEL_W  = 4,
  parameter int LVL    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*GROUPS*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic                      src_valid,
  output logic                      ready,
  output logic [GROUPS*WIDTH-1:0]   data,
  output logic [SEL_W-1:0]          sel,
  output logic                      valid,
  input  logic                      dst_ready
);

  logic [1:0]              pick;
  logic [GROUPS*WIDTH-1:0] picked;

  // This level consumes its own two select bits; the rest ride along.
  assign pick = src_sel[2*LVL +: 2];

  always_comb begin
    picked = '0;
    for (int g = 0; g < GROUPS; g++) begin
      picked[g*WIDTH +: WIDTH] = src_data[(4*g + int'(pick))*WIDTH +: WIDTH];
    end
  end

  // An empty level always accepts, so bubbles collapse toward the output.
  assign ready = dst_ready | ~valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sel   <= '0;
    end else if (ready) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= picked;
        sel  <= src_sel;
      end
    end
  end

endmodule

// File: rtl/mux_tree_pipelined.sv
// rtl/mux_tree_pipelined.sv - N_IN:1 mux as a pipelined tree of 4:1 stages
//
// Purpose: forwards channel in_sel of in_data to out_data, one tree level per
// pipeline stage, with valid/ready handshakes and the select echoed on out_sel.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      N_IN words, channel c at [c*WIDTH +: WIDTH]
//   in_sel       channel index to forward
//   in_valid     in_data/in_sel valid
//   in_ready     block accepts this cycle
//   out_data     selected word
//   out_sel      select that produced out_data
//   out_valid    out_data/out_sel valid
//   out_ready    consumer accepts this cycle

module mux_tree_pipelined
  import mux_tree_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  N_IN   = 16,
  localparam int LEVELS = clog4(N_IN),
  localparam int SEL_W  = 2 * LEVELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  `MUX_TREE_ASSERT_POW4(N_IN)

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int GROUPS = stage_words(N_IN, k);

    logic [4*GROUPS*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]          src_sel;
    logic                      src_valid;
    logic                      dst_ready;
    logic [GROUPS*WIDTH-1:0]   data;
    logic [SEL_W-1:0]          sel;
    logic                      valid;
    logic                      ready;

    if (k == 0) begin : g_head
      assign src_data  = in_data;
      assign src_sel   = in_sel;
      assign src_valid = in_valid;
    end else begin : g_link
      assign src_data  = g_stage[k-1].data;
      assign src_sel   = g_stage[k-1].sel;
      assign src_valid = g_stage[k-1].valid;
    end

    // Ready ripples back from the consumer through every level in one cycle.
    if (k == LEVELS - 1) begin : g_tail
      assign dst_ready = out_ready;
    end else begin : g_inner
      assign dst_ready = g_stage[k+1].ready;
    end

    mux4_stage #(
      .WIDTH  (WIDTH),
      .GROUPS (GROUPS),
      .SEL_W  (SEL_W),
      .LVL    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_data  (src_data),
      .src_sel   (src_sel),
      .src_valid (src_valid),
      .ready     (ready),
      .data      (data),
      .sel       (sel),
      .valid     (valid),
      .dst_ready (dst_ready)
    );
  end

  assign in_ready  = g_stage[0].ready;
  assign out_data  = g_stage[LEVELS-1].data;
  assign out_sel   = g_stage[LEVELS-1].sel;
  assign out_valid = g_stage[LEVELS-1].valid;

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// tb/tb_mux_tree_pipelined.sv - scoreboard bench for the pipelined mux tree

module tb_mux_tree_pipelined;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: 16 x 8 (latency 2), B: 4 x 1 (latency 1), C: 64 x 16 (latency 3)
  logic [127:0]  a_in_data;
  logic [3:0]    a_in_sel, a_out_sel;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]    a_out_data;

  logic [3:0]    b_in_data;
  logic [1:0]    b_in_sel, b_out_sel;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0]    b_out_data;

  logic [1023:0] c_in_data;
  logic [5:0]    c_in_sel, c_out_sel;
  logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0]   c_out_data;

  mux_tree_pipelined #(.WIDTH(8), .N_IN(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_tree_pipelined #(.WIDTH(1), .N_IN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  mux_tree_pipelined #(.WIDTH(16), .N_IN(64)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_sel(c_out_sel), .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {sel, word} per accepted item: the word is simply channel sel.
  logic [11:0] qa[$];
  logic [2:0]  qb[$];
  logic [21:0] qc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      if (a_in_valid && a_in_ready) qa.push_back({a_in_sel, a_in_data[a_in_sel*8 +: 8]});
      if (b_in_valid && b_in_ready) qb.push_back({b_in_sel, b_in_data[b_in_sel]});
      if (c_in_valid && c_in_ready) qc.push_back({c_in_sel, c_in_data[c_in_sel*16 +: 16]});
    end
  end

  // Monitor: pops on every output handshake, and checks hold under stall.
  logic        a_pv = 1'b0, a_pr = 1'b0, c_pv = 1'b0, c_pr = 1'b0;
  logic [11:0] a_prev;
  logic [21:0] c_prev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_pv && !a_pr) chk("a_stall_hold", {a_out_valid, a_out_sel, a_out_data}, {1'b1, a_prev});
      if (c_pv && !c_pr) chk("c_stall_hold", {c_out_valid, c_out_sel, c_out_data}, {1'b1, c_prev});
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_output", 1, 0);
        else chk("a_scoreboard", {a_out_sel, a_out_data}, qa.pop_front());
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_output", 1, 0);
        else chk("b_scoreboard", {b_out_sel, b_out_data}, qb.pop_front());
      end
      if (c_out_valid && c_out_ready) begin
        if (qc.size() == 0) chk("c_unexpected_output", 1, 0);
        else chk("c_scoreboard", {c_out_sel, c_out_data}, qc.pop_front());
      end
    end
    a_pv <= a_out_valid & rst_n;
    a_pr <= a_out_ready;
    a_prev <= {a_out_sel, a_out_data};
    c_pv <= c_out_valid & rst_n;
    c_pr <= c_out_ready;
    c_prev <= {c_out_sel, c_out_data};
  end

  task automatic chk_a_idle(input string name);
    chk({name, "_valid"}, a_out_valid, 0);
    chk({name, "_data"}, a_out_data, 0);
    chk({name, "_sel"}, a_out_sel, 0);
    chk({name, "_in_ready"}, a_in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_sel = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_sel = 0; b_in_data = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_sel = 0; c_in_data = '0; c_out_ready = 1;
    for (int c = 0; c < 16; c++) a_in_data[c*8 +: 8] = 8'h10 + 8'(c);

    // reset state and first cycle after release
    tick();
    chk_a_idle("rst_hold");
    chk("rst_hold_b_valid", b_out_valid, 0);
    chk("rst_hold_c_valid", c_out_valid, 0);
    rst_n = 1'b1;
    tick();
    chk_a_idle("rst_release");

    // single item, sel B
    a_in_valid = 1; a_in_sel = 4'hB;
    tick();
    a_in_valid = 0;
    chk("single_early", a_out_valid, 0);
    tick();
    chk("single_valid", a_out_valid, 1);
    chk("single_data", a_out_data, 8'h1B);
    chk("single_sel", a_out_sel, 4'hB);
    tick();
    chk("single_one_cycle", a_out_valid, 0);

    // back-to-back stream 0..15
    for (int i = 0; i < 18; i++) begin
      a_in_valid = (i < 16);
      a_in_sel = 4'(i);
      tick();
      if (i >= 1 && i <= 16) begin
        chk("stream_valid", a_out_valid, 1);
        chk("stream_data", a_out_data, 8'h10 + 8'(i - 1));
      end else begin
        chk("stream_gap", a_out_valid, 0);
      end
    end
    a_in_valid = 0;

    // backpressure: third push blocked, output held, then drained in order
    a_out_ready = 0;
    a_in_valid = 1; a_in_sel = 4'd3;
    chk("bp_first_ready", a_in_ready, 1);
    tick();
    a_in_sel = 4'd7;
    chk("bp_second_ready", a_in_ready, 1);
    tick();
    a_in_sel = 4'd9;
    chk("bp_third_blocked", a_in_ready, 0);
    tick();
    tick();
    chk("bp_hold_valid", a_out_valid, 1);
    chk("bp_hold_data", a_out_data, 8'h13);
    chk("bp_hold_sel", a_out_sel, 4'd3);
    chk("bp_still_blocked", a_in_ready, 0);
    a_out_ready = 1;
    #1;
    chk("bp_pop_push_ready", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    chk("bp_out2", {a_out_valid, a_out_data}, {1'b1, 8'h17});
    tick();
    chk("bp_out3", {a_out_valid, a_out_data}, {1'b1, 8'h19});
    tick();
    chk("bp_drained", a_out_valid, 0);

    // bubble collapse
    a_out_ready = 0;
    a_in_valid = 1; a_in_sel = 4'd1;
    tick();
    a_in_valid = 0;
    tick();
    a_in_valid = 1; a_in_sel = 4'd2;
    tick();
    a_in_valid = 0;
    chk("bubble_full", a_in_ready, 0);
    chk("bubble_head", {a_out_valid, a_out_data}, {1'b1, 8'h11});
    tick();
    chk("bubble_head_held", {a_out_valid, a_out_data}, {1'b1, 8'h11});
    a_out_ready = 1;
    tick();
    chk("bubble_next", {a_out_valid, a_out_data}, {1'b1, 8'h12});
    tick();
    chk("bubble_empty", a_out_valid, 0);

    // asynchronous reset with items in flight
    a_out_ready = 0;
    a_in_valid = 1; a_in_sel = 4'd5;
    tick();
    a_in_sel = 4'd6;
    tick();
    a_in_valid = 0;
    chk("midrst_loaded", a_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a_idle("midrst_async");
    tick();
    tick();
    rst_n = 1'b1;
    a_out_ready = 1;
    tick();
    chk_a_idle("midrst_release");
    tick();
    chk("midrst_discarded", a_out_valid, 0);

    // randomized traffic on all three configurations
    for (int cyc = 0; cyc < 20000; cyc++) begin
      for (int j = 0; j < 4; j++) a_in_data[j*32 +: 32] = $urandom();
      for (int j = 0; j < 32; j++) c_in_data[j*32 +: 32] = $urandom();
      b_in_data = 4'($urandom_range(0, 15));
      a_in_sel = 4'($urandom_range(0, 15));
      b_in_sel = 2'($urandom_range(0, 3));
      c_in_sel = 6'($urandom_range(0, 63));
      a_in_valid = ($urandom_range(0, 3) != 0);
      b_in_valid = ($urandom_range(0, 3) != 0);
      c_in_valid = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 9) < 7);
      b_out_ready = ($urandom_range(0, 9) < 7);
      c_out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
    a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
    repeat (8) tick();
    chk("a_drain_empty", qa.size(), 0);
    chk("b_drain_empty", qb.size(), 0);
    chk("c_drain_empty", qc.size(), 0);
    chk("drain_valids", {a_out_valid, b_out_valid, c_out_valid}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
